// File: rtl/divider_pkg.sv
// Shared CPU package: divider state encoding and default width.
package divider_pkg;
    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/divider_div_step.sv
// One restoring-division step: shift in dividend MSB, trial-subtract, restore.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, msb_i};
    // rem_i < dvs_i keeps the difference inside WIDTH+1 bits, so bit WIDTH is the sign
    assign diff    = shifted - {1'b0, dvs_i};
    assign qbit_o  = ~diff[WIDTH];
    assign rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (prem_q),
        .msb_i  (dvd_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bi != '0) begin
                        dvd_d   = ai;
                        dvs_d   = bi;
                        prem_d  = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = RUN;
                    end else begin
                        quot_d  = '1;
                        rem_d   = ai;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // abort wins over the final iteration and leaves results untouched
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    prem_d = step_rem;
                    dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quot_d  = {dvd_q[WIDTH-2:0], step_qbit};
                        rem_d   = step_rem;
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign dz   = dz_q;
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench: directed WIDTH=32 scenarios plus a random WIDTH=8 regression.
module tb_divider;
    import divider_pkg::*;

    localparam int LANES = 4;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp32_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp8_t;

    logic        clk;
    logic        reset_n;
    logic        start32, abort32;
    logic [31:0] ai32, bi32;
    logic        busy32, done32, dz32;
    logic [31:0] quot32, rem32;

    logic        start8;
    logic [7:0]  ai8   [LANES];
    logic [7:0]  bi8   [LANES];
    logic        busy8 [LANES];
    logic        done8 [LANES];
    logic        dz8   [LANES];
    logic [7:0]  quot8 [LANES];
    logic [7:0]  rem8  [LANES];

    int n_chk;
    int n_fail;
    int cyc;
    int t0;
    int done_cnt32;
    int ndone_exp;

    exp32_t q32[$];
    exp8_t  q8[LANES][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    divider #(.WIDTH(32)) u_dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start32),
        .abort   (abort32),
        .ai      (ai32),
        .bi      (bi32),
        .busy    (busy32),
        .done    (done32),
        .dz      (dz32),
        .quot    (quot32),
        .rem     (rem32)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        divider #(.WIDTH(8)) u_dut8 (
            .clk     (clk),
            .reset_n (reset_n),
            .start   (start8),
            .abort   (1'b0),
            .ai      (ai8[g]),
            .bi      (bi8[g]),
            .busy    (busy8[g]),
            .done    (done8[g]),
            .dz      (dz8[g]),
            .quot    (quot8[g]),
            .rem     (rem8[g])
        );

        always @(negedge clk) begin
            if (done8[g]) begin
                if (q8[g].size() == 0) begin
                    chk("w8 unexpected done", 64'(1), 64'(0));
                end else begin
                    exp8_t e;
                    e = q8[g].pop_front();
                    chk("w8 model", 64'({quot8[g], rem8[g], dz8[g]}),
                        64'({e.q, e.r, e.dz}));
                    if (e.b != 8'd0) begin
                        chk("w8 identity",
                            64'(int'(quot8[g]) * int'(e.b) + int'(rem8[g])),
                            64'(int'(e.a)));
                        chk("w8 rem<bi", 64'(rem8[g] < e.b), 64'(1));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done32) begin
            done_cnt32++;
            if (q32.size() == 0) begin
                chk("w32 unexpected done", 64'(1), 64'(0));
            end else begin
                exp32_t e;
                e = q32.pop_front();
                chk("w32 quot", 64'(quot32), 64'(e.q));
                chk("w32 rem", 64'(rem32), 64'(e.r));
                chk("w32 dz", 64'(dz32), 64'(e.dz));
            end
        end
    end

    function automatic exp32_t model32(input logic [31:0] a, input logic [31:0] b);
        exp32_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.dz = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic push32(input logic [31:0] a, input logic [31:0] b);
        q32.push_back(model32(a, b));
        ndone_exp++;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        ai32 = a;
        bi32 = b;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start32 = 1'b0;
        ai32 = $urandom;
        bi32 = $urandom;
    endtask

    task automatic wait_done32(output int lat, output int nb);
        lat = -1;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy32) nb++;
            if (done32) begin
                lat = cyc - t0 + 1;
                return;
            end
        end
        chk("w32 done timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int lat, nb;
        logic [7:0] a, b;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        done_cnt32 = 0;
        ndone_exp = 0;
        reset_n = 1'b0;
        start32 = 1'b0;
        abort32 = 1'b0;
        ai32 = '0;
        bi32 = '0;
        start8 = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            ai8[l] = '0;
            bi8[l] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset quot", 64'(quot32), 64'(0));
        chk("reset rem", 64'(rem32), 64'(0));
        chk("reset busy/done/dz", 64'({busy32, done32, dz32}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        do_start(32'd100, 32'd7);
        push32(32'd100, 32'd7);
        wait_done32(lat, nb);
        chk("100/7 latency", 64'(lat), 64'(33));
        chk("100/7 busy cycles", 64'(nb), 64'(32));

        do_start(32'h1234, 32'd0);
        push32(32'h1234, 32'd0);
        wait_done32(lat, nb);
        chk("dz latency", 64'(lat), 64'(1));
        chk("dz busy cycles", 64'(nb), 64'(0));

        do_start(32'hFFFF_FFFF, 32'd1);
        push32(32'hFFFF_FFFF, 32'd1);
        wait_done32(lat, nb);
        chk("max/1 latency", 64'(lat), 64'(33));
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32(lat, nb);
        chk("back-to-back latency", 64'(lat), 64'(33));

        do_start(32'd50, 32'd5);
        push32(32'd50, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        ai32 = 32'd9;
        bi32 = 32'd3;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        wait_done32(lat, nb);
        chk("ignored start latency", 64'(lat), 64'(33));
        repeat (40) @(negedge clk);
        chk("no queued start", 64'(done_cnt32), 64'(ndone_exp));

        do_start(32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        abort32 = 1'b1;
        @(posedge clk);
        #1;
        abort32 = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(busy32), 64'(0));
        chk("abort done", 64'(done32), 64'(0));
        chk("abort outputs held", 64'({quot32, rem32}), {32'd10, 32'd0});
        chk("abort dz held", 64'(dz32), 64'(0));
        repeat (40) @(negedge clk);
        chk("abort no done", 64'(done_cnt32), 64'(ndone_exp));

        do_start(32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async reset quot", 64'(quot32), 64'(0));
        chk("async reset rem", 64'(rem32), 64'(0));
        chk("async reset flags", 64'({busy32, done32, dz32}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset no done", 64'(done_cnt32), 64'(ndone_exp));
        do_start(32'd7, 32'd2);
        push32(32'd7, 32'd2);
        wait_done32(lat, nb);
        chk("post-reset latency", 64'(lat), 64'(33));

        for (int it = 0; it < 2600; it++) begin
            @(posedge clk);
            #1;
            for (int l = 0; l < LANES; l++) begin
                exp8_t e;
                a = 8'($urandom_range(0, 255));
                b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                ai8[l] = a;
                bi8[l] = b;
                e.a = a;
                e.b = b;
                if (b == 8'd0) begin
                    e.q = 8'hFF;
                    e.r = a;
                    e.dz = 1'b1;
                end else begin
                    e.q = 8'(int'(a) / int'(b));
                    e.r = 8'(int'(a) % int'(b));
                    e.dz = 1'b0;
                end
                q8[l].push_back(e);
            end
            start8 = 1'b1;
            @(posedge clk);
            #1;
            start8 = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                ai8[l] = 8'($urandom);
                bi8[l] = 8'($urandom);
            end
            repeat (8) @(posedge clk);
        end
        repeat (5) @(negedge clk);
        for (int l = 0; l < LANES; l++)
            chk("w8 queue drained", 64'(q8[l].size()), 64'(0));
        chk("w32 queue drained", 64'(q32.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width in bits (legal range 4..64).
REQ-002 The block SHALL have these ports:
  - clk, input, 1: the only clock; all state changes on its rising edge.
  - reset_n, input, 1: asynchronous, active-low reset.
  - start, input, 1: request a division; sampled only in IDLE.
  - abort, input, 1: synchronous cancel of the operation in progress.
  - ai, input, WIDTH: dividend (unsigned).
  - bi, input, WIDTH: divisor (unsigned).
  - busy, output, 1: high while an operation is in progress (RUN state).
  - done, output, 1: one-cycle pulse when the results become valid.
  - dz, output, 1: divide-by-zero flag for the last operation.
  - quot, output, WIDTH: quotient; feeds the ALU di input for the div opcode.
  - rem, output, WIDTH: remainder.

Function
REQ-003 The block SHALL implement a three-state machine with states IDLE, RUN and DONE.
REQ-004 In IDLE with start=1 and bi!=0, the block SHALL capture ai and bi, clear the partial remainder, load an iteration counter with WIDTH, and enter RUN.
REQ-005 In IDLE with start=1 and bi==0, the block SHALL enter DONE on the next edge with quot=all ones, rem=ai and dz=1.
REQ-006 RUN SHALL perform one restoring-division step per cycle, MSB first: shift {remainder, dividend} left by one, trial-subtract the divisor with a WIDTH+1-bit width, set the quotient bit to 1 if the result is non-negative, and restore otherwise.
REQ-007 RUN SHALL last exactly WIDTH cycles and then enter DONE.
REQ-008 done SHALL be 1 for exactly one cycle, while in DONE; DONE SHALL then return to IDLE unconditionally.
REQ-009 Latency SHALL be as follows, measured from the edge that samples start:
  - normal division: done high in cycle WIDTH+1;
  - divide-by-zero: done high in cycle 1.
REQ-010 quot, rem and dz SHALL update only on entry to DONE, and SHALL hold until the next DONE or reset.
REQ-011 The intermediate quotient and remainder SHALL never be visible on quot and rem.
REQ-012 start asserted in RUN or DONE SHALL be ignored; it SHALL not be queued.
REQ-013 A start asserted in the IDLE cycle that immediately follows DONE SHALL be accepted (back-to-back operation).
REQ-014 abort=1 in RUN SHALL move the state machine to IDLE on the next edge with:
  - no done pulse;
  - quot, rem and dz unchanged.
  abort has priority over iteration completion. abort in IDLE or DONE SHALL have no effect.
REQ-015 busy SHALL equal (state==RUN).
REQ-016 Results SHALL satisfy ai == quot*bi + rem and rem < bi for every bi != 0.
REQ-017 Operand changes on ai and bi after start has been sampled SHALL not affect the result.

Reset
REQ-018 reset_n=0 SHALL immediately and asynchronously force:
  - state to IDLE;
  - busy=0, done=0, dz=0;
  - quot=0, rem=0;
  - iteration counter and working registers to 0.
REQ-019 A reset during RUN SHALL discard the operation with no done pulse.
REQ-020 The first start after reset release SHALL be accepted normally.

Structure
REQ-021 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared CPU package.
REQ-022 One combinational sub-module, div_step, SHALL implement a single shift/trial-subtract/restore step (inputs: remainder, dividend MSB, divisor; outputs: next remainder, quotient bit).
REQ-023 divider SHALL instantiate exactly one div_step.
REQ-024 The iteration counter SHALL be clog2(WIDTH+1) bits wide.

Verification
REQ-025 The bench SHALL cover these directed scenarios (WIDTH=32 unless stated):
  - ai=100, bi=7, start pulse -> done in cycle 33, quot=14, rem=2, dz=0; busy high for cycles 1..32.
  - ai=0x1234, bi=0, start -> done in cycle 1, quot=0xFFFFFFFF, rem=0x1234, dz=1, busy never high.
  - ai=0xFFFFFFFF, bi=1, then back-to-back ai=0xFFFFFFFF, bi=0xFFFFFFFF -> quot=0xFFFFFFFF/rem=0, then quot=1/rem=0; second start accepted in the cycle after the first done.
  - ai=50, bi=5, start; start again with ai=9, bi=3 at cycle 10 -> second start ignored, result quot=10, rem=0.
  - ai=1000, bi=3, start; abort at cycle 5 -> IDLE at cycle 6, no done, outputs keep the prior values.
  - ai=1000, bi=3, start; reset_n low at cycle 12 -> outputs 0 immediately; after release, ai=7, bi=2 yields quot=3, rem=1.
REQ-026 A random regression of at least 10k operand pairs with WIDTH=8, including bi=0, SHALL be checked against REQ-016.
